// File: rtl/button_tick_gen.sv
// Debounced pushbutton to one-clock tick generator with a 2-flop input synchronizer.
// Optional auto-repeat while held is built when BUTTON_AUTOREPEAT_EN is defined.
module button_tick_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic tick,
  output logic pressed
);

  localparam int unsigned CW   = 26;
  localparam int unsigned MAXV = (2 ** CW) - 1;
  localparam logic [CW-1:0] DB_TGT = CW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > MAXV) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > MAXV) begin : g_bad_rd
    $error("REPEAT_DELAY out of range");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > MAXV) begin : g_bad_rp
    $error("REPEAT_PERIOD out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  state_t        state, state_n;
  logic          s1, s2;
  logic [CW-1:0] db_cnt, db_cnt_n, db_inc;
  logic          tick_n, pressed_n;

`ifdef BUTTON_AUTOREPEAT_EN
  // Spacing of 1 would put a repeat tick right after the previous one; clamp to 2.
  localparam logic [CW-1:0] RD_TGT = CW'((REPEAT_DELAY < 2) ? 2 : REPEAT_DELAY);
  localparam logic [CW-1:0] RP_TGT = CW'((REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD);
  logic [CW-1:0] rpt_cnt, rpt_cnt_n, rpt_inc;
  logic          rpt_phase, rpt_phase_n;
  assign rpt_inc = rpt_cnt + CW'(1);
`endif

  assign db_inc = db_cnt + CW'(1);

  always_comb begin
    state_n  = state;
    db_cnt_n = db_cnt;
    tick_n   = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
    // Defaulting to zero outside HELD restarts the delay phase on every HELD entry.
    rpt_cnt_n   = '0;
    rpt_phase_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        db_cnt_n = '0;
        if (s2) begin
          if (DB_TGT == CW'(1)) begin
            state_n = HELD;
            tick_n  = 1'b1;
          end else begin
            state_n  = PRESS_DB;
            db_cnt_n = CW'(1);
          end
        end
      end
      PRESS_DB: begin
        if (!s2) begin
          state_n  = IDLE;
          db_cnt_n = '0;
        end else if (db_inc == DB_TGT) begin
          state_n  = HELD;
          tick_n   = 1'b1;
          db_cnt_n = '0;
        end else begin
          db_cnt_n = db_inc;
        end
      end
      HELD: begin
        if (!s2) begin
          if (DB_TGT == CW'(1)) begin
            state_n  = IDLE;
            db_cnt_n = '0;
          end else begin
            state_n  = RELEASE_DB;
            db_cnt_n = CW'(1);
          end
        end else begin
`ifdef BUTTON_AUTOREPEAT_EN
          if (rpt_inc == (rpt_phase ? RP_TGT : RD_TGT)) begin
            tick_n      = 1'b1;
            rpt_cnt_n   = '0;
            rpt_phase_n = 1'b1;
          end else begin
            rpt_cnt_n   = rpt_inc;
            rpt_phase_n = rpt_phase;
          end
`endif
        end
      end
      RELEASE_DB: begin
        if (s2) begin
          state_n  = HELD;
          db_cnt_n = '0;
        end else if (db_inc == DB_TGT) begin
          state_n  = IDLE;
          db_cnt_n = '0;
        end else begin
          db_cnt_n = db_inc;
        end
      end
      default: begin
        state_n  = IDLE;
        db_cnt_n = '0;
      end
    endcase
    pressed_n = (state_n == HELD) || (state_n == RELEASE_DB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state   <= IDLE;
      db_cnt  <= '0;
      tick    <= 1'b0;
      pressed <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
`endif
    end else begin
      s1      <= btn_in;
      s2      <= s1;
      state   <= state_n;
      db_cnt  <= db_cnt_n;
      tick    <= tick_n;
      pressed <= pressed_n;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_cnt   <= rpt_cnt_n;
      rpt_phase <= rpt_phase_n;
`endif
    end
  end

endmodule

// File: tb/tb_button_tick_gen.sv
// Directed bench for button_tick_gen: main instance (debounce 4) plus a debounce-1 instance,
// expected outputs queued per driven step and compared one edge later.
module tb_button_tick_gen;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic tick, pressed, tick1, pressed1;

  always #5 clk = ~clk;

  button_tick_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .tick(tick),
    .pressed(pressed)
  );

  button_tick_gen #(
    .DEBOUNCE_CYCLES(1),
    .REPEAT_DELAY(3),
    .REPEAT_PERIOD(1)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .tick(tick1),
    .pressed(pressed1)
  );

  typedef struct packed {
    logic t;
    logic p;
    logic t1;
    logic p1;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    step  = 0;
  string tag   = "reset";

  // Reference for the debounce-1 instance: 2-flop sync, state follows the synced level.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_p  = 1'b0;
  int   m_j  = 0;

  function automatic bit rep(input int j, input int dly, input int per);
    return AR && (j >= dly) && (((j - dly) % per) == 0);
  endfunction

  task automatic cyc(input logic b, input logic r, input logic et, input logic ep);
    exp_t e;
    logic seen;
    logic t1;
    t1 = 1'b0;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_p = 1'b0; m_j = 0;
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      if (seen && !m_p) begin
        t1 = 1'b1; m_j = 0;
      end else if (seen) begin
        m_j++; t1 = rep(m_j, 3, 2);
      end else begin
        m_j = 0;
      end
      m_p = seen;
    end
    sb.push_back('{t: et, p: ep, t1: t1, p1: m_p});
    btn_in = b;
    rst    = r;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    assert ({tick, pressed} === {e.t, e.p}) else begin
      n_bad++;
      $error("FAIL %s step %0d: tick/pressed got %b%b expected %b%b", tag, step, tick, pressed, e.t, e.p);
    end
    n_cmp++;
    assert ({tick1, pressed1} === {e.t1, e.p1}) else begin
      n_bad++;
      $error("FAIL %s_db1 step %0d: tick/pressed got %b%b expected %b%b", tag, step, tick1, pressed1, e.t1, e.p1);
    end
    step++;
  endtask

  // Button high for steps [0,L), optional one-cycle reset at step rst_at (before HELD).
  task automatic run_press(input string name, input int L, input int total, input int rst_at);
    int h;
    tag  = name;
    step = 0;
    h    = (rst_at >= 0) ? (rst_at + 2 + D) : (1 + D);
    for (int k = 0; k < total; k++) begin
      cyc(k < L, k == rst_at,
          (k == h) || (k > h && k <= L + 1 && rep(k - h, RD, RP)),
          (k >= h) && (k < L + 1 + D));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tag = "idle";
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    run_press("clean", 20, 28, -1);

    tag  = "bounce";
    step = 0;
    for (int k = 0; k < 15; k++) begin
      cyc((k < 3) || (k >= 4 && k < 7), 1'b0, 1'b0, 1'b0);
    end
    run_press("after_bounce", 8, 16, -1);

    tag  = "rel_bounce";
    step = 0;
    for (int k = 0; k < 24; k++) begin
      cyc((k < 8) || (k >= 10 && k < 15), 1'b0, k == 5, (k >= 5) && (k < 20));
    end

    run_press("repeat", 36, 44, -1);
    run_press("rst_on_tick", 20, 28, 5);
    run_press("rst_early", 12, 20, 2);

    tag  = "rst_held";
    step = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(k < 10, k == 7, k == 5, (k == 5) || (k == 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_tick_gen.md
BUTTON_TICK_GEN -- requirements
Module: button_tick_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive clocks a new synchronized level must persist to be accepted; legal range 1 to 2^26-1.
REQ-002 Parameter REPEAT_DELAY, default 50000000, is the number of clocks held before the first auto-repeat tick; legal range 1 to 2^26-1.
REQ-003 Parameter REPEAT_PERIOD, default 20000000, is the number of clocks between subsequent auto-repeat ticks; legal range 1 to 2^26-1.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_in  input  1  raw asynchronous, bouncing pushbutton, active-high.
REQ-007 tick  output  1  one-clock pulse per accepted press (and per repeat); drives the step counter tick input.
REQ-008 pressed  output  1  debounced button level.

Function
REQ-009 btn_in shall pass through a 2-flop synchronizer; only the second flop (btn_sync) feeds the control logic.
REQ-010 FSM states: IDLE (released), PRESS_DB, HELD, RELEASE_DB; encoding free.
REQ-011 IDLE: btn_sync=1 -> PRESS_DB with debounce count loaded to 1; otherwise stay.
REQ-012 PRESS_DB: btn_sync=1 increments count; when count reaches DEBOUNCE_CYCLES -> HELD, tick=1 on that edge, pressed=1; btn_sync=0 -> IDLE, count cleared, no tick.
REQ-013 HELD: btn_sync=0 -> RELEASE_DB with count loaded to 1; pressed stays 1.
REQ-014 RELEASE_DB: btn_sync=0 increments count; when count reaches DEBOUNCE_CYCLES -> IDLE, pressed=0, no tick; btn_sync=1 -> HELD, count cleared.
REQ-015 DEBOUNCE_CYCLES=1 shall transition on the first edge seeing the new level.
REQ-016 Latency: btn_in high and stable from sampling edge E0 yields tick registered on edge E(1+DEBOUNCE_CYCLES).
REQ-017 tick shall never be high two consecutive cycles; REPEAT_PERIOD=1 is clamped internally to a 2-clock spacing.
REQ-018 All counters saturate-free: widths sized to 26 bits; no wrap possible within legal parameter range.
REQ-019 Outputs are registered; no combinational path btn_in -> tick or pressed.

Reset
REQ-020 On rst=1 at a clock edge: FSM -> IDLE, synchronizer flops, debounce and repeat counters -> 0, tick=0, pressed=0.
REQ-021 rst has priority over every other event, including a tick-producing transition on the same edge.
REQ-022 A button held through reset release shall be debounced anew and produce exactly one tick DEBOUNCE_CYCLES+2 edges after rst deasserts.

Configuration
REQ-023 Macro BUTTON_AUTOREPEAT_EN defined: in HELD a repeat counter runs; tick pulses after REPEAT_DELAY clocks in HELD, then every REPEAT_PERIOD clocks while HELD.
REQ-024 Repeat counter clears and returns to the delay phase on every entry to HELD, including return from RELEASE_DB; no repeat ticks in RELEASE_DB.
REQ-025 Macro undefined: no repeat counter is built; HELD produces no ticks; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 Clean press: btn_in 0->1 sampled at edge 0, held 20 clocks -> single tick after edge 5, pressed=1 from edge 5; macro off: no further ticks.
REQ-027 Bounce: btn_in high 3 clocks, low 1, high 3, low -> no tick, pressed stays 0, FSM back in IDLE.
REQ-028 Release bounce: from HELD, btn_in low 2 clocks then high -> pressed stays 1, no tick; then low 6 clocks -> pressed=0 after 4th low-sampled edge past synchronizer.
REQ-029 Autorepeat (macro on): hold 30 clocks after entering HELD -> ticks at HELD+0, +10, +13, +16, +19, +22, +25, +28.
REQ-030 Reset mid-press: rst pulsed 1 cycle during PRESS_DB at count 3, button held -> tick/pressed 0 during reset, tick 6 edges after rst deasserts, exactly once (macro off).
REQ-031 Reset during tick edge: rst high on the edge completing debounce -> tick=0, pressed=0, FSM IDLE.
